bus_decoder_rv32: RTL and testbench

- Sits directly downstream of the RV32 CPU wrapper.
- Decodes the CPU's one-cycle address strobe into four slave regions and gates writes to the selected slave.
- Returns read data from the selected slave one cycle after the strobe, which matches the wrapper's fixed one-cycle ready.
- Counts and captures accesses to unmapped addresses for debug.

---
 rtl/bus_decoder_rv32.sv | 131 +++++++++++++
 tb/tb_bus_decoder_rv32.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bus_decoder_rv32.sv
// bus_decoder_rv32: address decoder placed directly after the RV32 CPU wrapper.
// - Decodes the one-cycle CPU address strobe into four slave regions.
//   The lowest region index wins when regions overlap.
// - Gates write enables and byte strobes to the selected slave in the same cycle.
// - Returns the selected slave's read data one cycle after the strobe.
// - Optional build macro BUS_DECODER_ERR_CAPTURE_EN adds unmapped-access debug
//   capture: a sticky flag, a saturating count and the last faulting address.
//   Without it the err_* outputs are tied to 0 and err_clear_i is ignored.
module bus_decoder_rv32 #(
  parameter int                         address_width = 32,
  parameter logic [address_width-1:0]   BASE0         = 32'h0000_0000,
  parameter logic [address_width-1:0]   MASK0         = 32'hFFFF_C000,
  parameter logic [address_width-1:0]   BASE1         = 32'h0000_8000,
  parameter logic [address_width-1:0]   MASK1         = 32'hFFFF_FF00,
  parameter logic [address_width-1:0]   BASE2         = 32'h0000_9000,
  parameter logic [address_width-1:0]   MASK2         = 32'hFFFF_FF00,
  parameter logic [address_width-1:0]   BASE3         = 32'h0000_A000,
  parameter logic [address_width-1:0]   MASK3         = 32'hFFFF_FF00,
  parameter logic [31:0]                UNMAPPED_DATA = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic [31:0]              cpu_data_i,
  input  logic                     cpu_we_i,
  input  logic [3:0]               cpu_we_ram_i,
  output logic [31:0]              cpu_rdata_o,
  output logic [address_width-1:0] slave_addr_o,
  output logic [31:0]              slave_wdata_o,
  output logic [3:0]               slave_sel_o,
  output logic [3:0]               slave_we_o,
  output logic [3:0]               slave_wstrb_o,
  input  logic [127:0]             slave_rdata_i,
  input  logic                     err_clear_i,
  output logic                     err_valid_o,
  output logic [15:0]              err_count_o,
  output logic [address_width-1:0] err_addr_o
);

  localparam logic [3:0][address_width-1:0] LP_BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [3:0][address_width-1:0] LP_MASK = {MASK3, MASK2, MASK1, MASK0};

  logic [3:0]               w_hit;
  logic [3:0]               w_sel;
  logic [1:0]               w_sel_idx;
  logic                     w_hit_any;
  logic [address_width-1:0] w_offset;
  logic [1:0]               r_sel_q;
  logic                     r_hit_any_q;

  // Raw per-region match against base/mask
  always_comb begin
    w_hit = '0;
    for (int n = 0; n < 4; n++) begin
      w_hit[n] = ((cpu_address_i & LP_MASK[n]) == LP_BASE[n]);
    end
  end

  // Priority select: scan high to low so the lowest hitting region wins
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    w_offset  = '0;
    for (int n = 3; n >= 0; n--) begin
      if (w_hit[n]) begin
        w_sel     = 4'(1 << n);
        w_sel_idx = 2'(n);
        w_offset  = cpu_address_i & ~LP_MASK[n];
      end
    end
  end

  assign w_hit_any     = |w_hit;
  assign slave_sel_o   = w_sel;
  assign slave_addr_o  = w_offset;
  assign slave_wdata_o = cpu_data_i;
  assign slave_we_o    = {4{cpu_we_i}} & w_sel;
  assign slave_wstrb_o = w_hit_any ? cpu_we_ram_i : 4'b0000;

  // Register the decode so read data lines up with the slaves' 1-cycle read
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sel_q     <= '0;
      r_hit_any_q <= 1'b0;
    end else begin
      r_sel_q     <= w_sel_idx;
      r_hit_any_q <= w_hit_any;
    end
  end

  assign cpu_rdata_o = r_hit_any_q ? slave_rdata_i[{r_sel_q, 5'b00000} +: 32] : UNMAPPED_DATA;

`ifdef BUS_DECODER_ERR_CAPTURE_EN
  logic                     w_unmapped;
  logic                     r_err_valid;
  logic [15:0]              r_err_count;
  logic [address_width-1:0] r_err_addr;

  // Idle (address 0) is never an error
  assign w_unmapped = (cpu_address_i != '0) & ~w_hit_any;

  // Error capture; a new event in the clear cycle wins over the clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_valid <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (w_unmapped) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= cpu_address_i;
      if (err_clear_i)                  r_err_count <= 16'd1;
      else if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end else if (err_clear_i) begin
      r_err_valid <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_count_o = r_err_count;
  assign err_addr_o  = r_err_addr;
`else
  logic w_unused_clear;
  assign w_unused_clear = err_clear_i;
  assign err_valid_o    = 1'b0;
  assign err_count_o    = '0;
  assign err_addr_o     = '0;
`endif

endmodule

// File: tb/tb_bus_decoder_rv32.sv
// Directed bench for bus_decoder_rv32; expectations switch on BUS_DECODER_ERR_CAPTURE_EN.
module tb_bus_decoder_rv32;

`ifdef BUS_DECODER_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr, wdata, rdata, saddr, swdata, eaddr;
  logic         we, eclr, evalid;
  logic [3:0]   we_ram, sel, swe, swstrb;
  logic [127:0] srdata;
  logic [15:0]  ecount;
  int           total = 0;
  int           bad   = 0;

  bus_decoder_rv32 dut (
    .clk_i(clk), .reset_i(rst), .cpu_address_i(addr), .cpu_data_i(wdata),
    .cpu_we_i(we), .cpu_we_ram_i(we_ram), .cpu_rdata_o(rdata),
    .slave_addr_o(saddr), .slave_wdata_o(swdata), .slave_sel_o(sel),
    .slave_we_o(swe), .slave_wstrb_o(swstrb), .slave_rdata_i(srdata),
    .err_clear_i(eclr), .err_valid_o(evalid), .err_count_o(ecount), .err_addr_o(eaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e(input logic [31:0] v);
    return CAP ? v : 32'h0;
  endfunction

  // Apply a strobe at the falling edge; caller checks comb outputs after #1
  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic c);
    @(negedge clk);
    addr = a; we = w; we_ram = s; wdata = d; eclr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; we_ram = '0; eclr = 1'b0;
    srdata = {4{32'h1234_5678}};
    tick();
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_count",  {16'h0, ecount}, 32'h0);
    chk("rst_valid",  {31'h0, evalid}, 32'h0);
    chk("rst_eaddr",  eaddr, 32'h0);
    chk("idle_sel",   {28'h0, sel}, 32'h1);
    @(negedge clk); rst = 1'b0;
    srdata = {32'h3333_0000, 32'h2222_0000, 32'hCAFE_0001, 32'h1111_0000};

    // read region 1
    drive(32'h0000_8004, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("r1_sel",   {28'h0, sel}, 32'h2);
    chk("r1_saddr", saddr, 32'h4);
    chk("r1_we",    {28'h0, swe}, 32'h0);
    chk("r1_wstrb", {28'h0, swstrb}, 32'h0);
    tick();
    chk("r1_rdata", rdata, 32'hCAFE_0001);

    // write region 2
    drive(32'h0000_9010, 1'b1, 4'b0011, 32'hA5A5_5A5A, 1'b0);
    chk("w2_sel",   {28'h0, sel}, 32'h4);
    chk("w2_we",    {28'h0, swe}, 32'h4);
    chk("w2_wstrb", {28'h0, swstrb}, 32'h3);
    chk("w2_wdata", swdata, 32'hA5A5_5A5A);
    chk("w2_saddr", saddr, 32'h10);
    tick();
    chk("w2_rdata", rdata, 32'h2222_0000);

    // region 3 top byte, region 0 top word
    drive(32'h0000_A0FF, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("r3_sel",   {28'h0, sel}, 32'h8);
    chk("r3_saddr", saddr, 32'hFF);
    tick();
    chk("r3_rdata", rdata, 32'h3333_0000);
    drive(32'h0000_3FFC, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("r0_sel",   {28'h0, sel}, 32'h1);
    chk("r0_saddr", saddr, 32'h3FFC);
    tick();
    chk("r0_rdata", rdata, 32'h1111_0000);

    // idle is region 0 and never an error
    drive(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();
    chk("idle_rdata", rdata, 32'h1111_0000);
    chk("idle_valid", {31'h0, evalid}, 32'h0);

    // three unmapped accesses, last is a write
    for (int i = 0; i < 3; i++) begin
      drive(32'h0001_0000, i == 2, 4'hF, 32'hDEAD_BEEF, 1'b0);
      chk("um_sel",   {28'h0, sel}, 32'h0);
      chk("um_we",    {28'h0, swe}, 32'h0);
      chk("um_wstrb", {28'h0, swstrb}, 32'h0);
      chk("um_saddr", saddr, 32'h0);
      tick();
    end
    chk("um_count", {16'h0, ecount}, e(32'h3));
    chk("um_eaddr", eaddr, e(32'h0001_0000));
    chk("um_valid", {31'h0, evalid}, e(32'h1));
    chk("um_rdata", rdata, 32'h0);

    // clear with a new event, then clear alone
    drive(32'h0002_0000, 1'b0, 4'h0, 32'h0, 1'b1);
    tick();
    chk("clrev_count", {16'h0, ecount}, e(32'h1));
    chk("clrev_eaddr", eaddr, e(32'h0002_0000));
    chk("clrev_valid", {31'h0, evalid}, e(32'h1));
    drive(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    tick();
    chk("clr_count", {16'h0, ecount}, 32'h0);
    chk("clr_valid", {31'h0, evalid}, 32'h0);
    chk("clr_eaddr", eaddr, 32'h0);

    // just past region 1 is unmapped
    drive(32'h0000_8100, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("b1_sel", {28'h0, sel}, 32'h0);
    tick();
    chk("b1_count", {16'h0, ecount}, e(32'h1));
    chk("b1_eaddr", eaddr, e(32'h0000_8100));
    drive(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    tick();

    // saturation: 65534 events then two more
    drive(32'h0003_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'h0, ecount}, e(32'hFFFE));
    tick();
    chk("sat_ffff_a", {16'h0, ecount}, e(32'hFFFF));
    tick();
    chk("sat_ffff_b", {16'h0, ecount}, e(32'hFFFF));
    chk("sat_valid",  {31'h0, evalid}, e(32'h1));

    // reset with a read in flight
    drive(32'h0000_8004, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();
    chk("pre_rst_rdata", rdata, 32'hCAFE_0001);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_count", {16'h0, ecount}, 32'h0);
    chk("mid_rst_valid", {31'h0, evalid}, 32'h0);
    @(negedge clk); rst = 1'b0; addr = '0;
    tick();
    chk("post_rst_rdata", rdata, 32'h1111_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
